// File: rtl/omok_pkg.sv
// Shared definitions for the omok game controller: board geometry, cell and
// winner encodings, controller states and the line-walk direction table.
package omok_pkg;

  localparam int MAP_N = 10;
  localparam int CELLS = MAP_N * MAP_N;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b10;
  localparam logic [1:0] CELL_WHITE = 2'b11;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_BLACK = 2'b10;
  localparam logic [1:0] WIN_WHITE = 2'b11;
  localparam logic [1:0] WIN_DRAW  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_GAMEOVER = 2'd2
  } state_t;

  // Row/column step per direction: horizontal, vertical, main diagonal, anti-diagonal
  localparam int DIR_DR [4] = '{0, 1, 1, 1};
  localparam int DIR_DC [4] = '{1, 0, 1, -1};

  function automatic logic [1:0] stone_of(input logic side);
    return side ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/omok_game_ctrl_if.sv
// Request/status bundle between a game front-end (master) and the controller (slave).
interface omok_game_ctrl_if #(
  parameter int MAP_N = omok_pkg::MAP_N
);
  logic [7:0]               cursor_pos;
  logic                     put_req;
  logic                     undo_req;
  logic [2*MAP_N*MAP_N-1:0] board_state;
  logic                     turn;
  logic [6:0]               move_count;
  logic                     busy;
  logic                     game_over;
  logic [1:0]               winner;
  logic                     reject;

  modport master (
    output cursor_pos, put_req, undo_req,
    input  board_state, turn, move_count, busy, game_over, winner, reject
  );

  modport slave (
    input  cursor_pos, put_req, undo_req,
    output board_state, turn, move_count, busy, game_over, winner, reject
  );
endinterface

// File: rtl/omok_move_stack.sv
// Move history LIFO: push on placement, pop on undo; top is the most recent cell index.
// Single-cycle update; pushes beyond DEPTH and pops when empty are ignored.
module omok_move_stack #(
  parameter int DEPTH = omok_pkg::CELLS,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic         pop_vld,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic [6:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] hist_mem [DEPTH];
  logic [6:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop_vld && (count_q != 7'd0);
    do_push = push_vld && !pop_vld && (int'(count_q) < DEPTH);
    count_d = count_q;
    if (do_pop) begin
      count_d = count_q - 7'd1;
    end else if (do_push) begin
      count_d = count_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever read
  always_ff @(posedge clk) begin
    if (do_push) begin
      hist_mem[AW'(count_q)] <= push_dat;
    end
  end

  assign top_dat = (count_q != 7'd0) ? hist_mem[AW'(count_q - 7'd1)] : '0;
  assign count   = count_q;

endmodule

// File: rtl/omok_game_ctrl.sv
// Omok (gomoku) referee: places/undoes stones and walks four line directions
// one probed cell per cycle after each placement to detect a win or draw.
module omok_game_ctrl #(
  parameter int MAP_N   = omok_pkg::MAP_N,
  parameter int WIN_LEN = 5
) (
  input  logic            clk,
  input  logic            rst,
  omok_game_ctrl_if.slave io
);
  import omok_pkg::*;

  localparam int NCELLS = MAP_N * MAP_N;

  state_t                state_q, state_d;
  logic [2*NCELLS-1:0]   board_q, board_d;
  logic                  turn_q, turn_d;
  logic [1:0]            winner_q, winner_d;
  logic                  reject_q, reject_d;
  logic                  armed_q, armed_d;
  logic [7:0]            org_r_q, org_r_d, org_c_q, org_c_d;
  logic [1:0]            colour_q, colour_d;
  logic [1:0]            dir_q, dir_d;
  logic                  neg_q, neg_d;
  logic [7:0]            step_q, step_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  push_vld, pop_vld;
  logic [6:0]            top_dat, mc;

  int                    pos_i, cur_idx, top_i, sgn, pr, pc, pidx;
  logic                  pos_ok, cur_empty, in_b, match, walk_end, put_go, undo_go;

  omok_move_stack #(.DEPTH(NCELLS), .W(7)) u_stack (
    .clk      (clk),
    .rst_n    (rst),
    .push_vld (push_vld),
    .pop_vld  (pop_vld),
    .push_dat (io.cursor_pos[6:0]),
    .top_dat  (top_dat),
    .count    (mc)
  );

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    reject_d = 1'b0;
    armed_d  = 1'b1;
    org_r_d  = org_r_q;
    org_c_d  = org_c_q;
    colour_d = colour_q;
    dir_d    = dir_q;
    neg_d    = neg_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    push_vld = 1'b0;
    pop_vld  = 1'b0;
    walk_end = 1'b0;

    // Requests are held off until one edge after reset release
    put_go    = io.put_req && armed_q;
    undo_go   = io.undo_req && armed_q;
    pos_i     = int'(io.cursor_pos);
    pos_ok    = pos_i < NCELLS;
    cur_idx   = pos_ok ? pos_i : 0;
    cur_empty = pos_ok && (board_q[2*cur_idx +: 2] == CELL_EMPTY);
    top_i     = int'(top_dat);

    // Current probe: origin offset by step cells along the active direction and sign
    sgn   = neg_q ? -1 : 1;
    pr    = int'(org_r_q) + sgn * DIR_DR[dir_q] * int'(step_q);
    pc    = int'(org_c_q) + sgn * DIR_DC[dir_q] * int'(step_q);
    in_b  = (pr >= 0) && (pr < MAP_N) && (pc >= 0) && (pc < MAP_N);
    pidx  = in_b ? (pr * MAP_N + pc) : 0;
    match = in_b && (board_q[2*pidx +: 2] == colour_q);

    unique case (state_q)
      ST_IDLE: begin
        if (undo_go) begin
          if (mc == 7'd0) begin
            reject_d = 1'b1;
          end else begin
            pop_vld  = 1'b1;
            board_d[2*top_i +: 2] = CELL_EMPTY;
            winner_d = WIN_NONE;
            turn_d   = ~turn_q;
          end
        end else if (put_go) begin
          if (cur_empty) begin
            board_d[2*cur_idx +: 2] = stone_of(turn_q);
            push_vld = 1'b1;
            org_r_d  = 8'(cur_idx / MAP_N);
            org_c_d  = 8'(cur_idx % MAP_N);
            colour_d = stone_of(turn_q);
            dir_d    = 2'd0;
            neg_d    = 1'b0;
            step_d   = 8'd1;
            cnt_d    = 8'd1;
            state_d  = ST_CHECK;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        if (put_go || undo_go) begin
          reject_d = 1'b1;
        end
        if (match) begin
          if (int'(cnt_q) + 1 >= WIN_LEN) begin
            state_d  = ST_GAMEOVER;
            winner_d = colour_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (int'(step_q) >= WIN_LEN - 1) begin
              walk_end = 1'b1;
            end else begin
              step_d = step_q + 8'd1;
            end
          end
        end else begin
          walk_end = 1'b1;
        end
        // Count carries from the positive walk into the negative walk of one direction
        if (walk_end) begin
          step_d = 8'd1;
          if (!neg_q) begin
            neg_d = 1'b1;
          end else if (dir_q != 2'd3) begin
            dir_d = dir_q + 2'd1;
            neg_d = 1'b0;
            cnt_d = 8'd1;
          end else if (int'(mc) == NCELLS) begin
            state_d  = ST_GAMEOVER;
            winner_d = WIN_DRAW;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAMEOVER: begin
        // The finishing move never toggled turn, so undo leaves it with the mover
        if (undo_go) begin
          if (mc == 7'd0) begin
            reject_d = 1'b1;
          end else begin
            pop_vld  = 1'b1;
            board_d[2*top_i +: 2] = CELL_EMPTY;
            winner_d = WIN_NONE;
            state_d  = ST_IDLE;
          end
        end else if (put_go) begin
          reject_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      board_q  <= '0;
      turn_q   <= 1'b0;
      winner_q <= WIN_NONE;
      reject_q <= 1'b0;
      armed_q  <= 1'b0;
      org_r_q  <= '0;
      org_c_q  <= '0;
      colour_q <= CELL_EMPTY;
      dir_q    <= '0;
      neg_q    <= 1'b0;
      step_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      reject_q <= reject_d;
      armed_q  <= armed_d;
      org_r_q  <= org_r_d;
      org_c_q  <= org_c_d;
      colour_q <= colour_d;
      dir_q    <= dir_d;
      neg_q    <= neg_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  assign io.board_state = board_q;
  assign io.turn        = turn_q;
  assign io.move_count  = mc;
  assign io.busy        = (state_q == ST_CHECK);
  assign io.game_over   = (state_q == ST_GAMEOVER);
  assign io.winner      = winner_q;
  assign io.reject      = reject_q;

endmodule

// File: tb/tb_omok_game_ctrl.sv
// Directed bench for omok_game_ctrl: a reference game model pushes expected
// results per request; they are popped and compared once the controller settles.
module tb_omok_game_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  omok_game_ctrl_if #(.MAP_N(10)) io ();

  omok_game_ctrl #(.MAP_N(10), .WIN_LEN(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    bit           rej;
    logic [199:0] board;
    int           mc;
    bit           turn;
    bit           go;
    logic [1:0]   win;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mb [100];
  int         hist[$];
  int         mcount;
  bit         mturn, mgo;
  logic [1:0] mwin;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 100; k++) mb[k] = 2'b00;
    hist.delete();
    sb.delete();
    mcount = 0;
    mturn  = 1'b0;
    mgo    = 1'b0;
    mwin   = 2'b00;
  endfunction

  function automatic logic [199:0] pack_board();
    logic [199:0] v = '0;
    for (int k = 0; k < 100; k++) v[2*k +: 2] = mb[k];
    return v;
  endfunction

  // Brute-force scan for five in a row of colour c anywhere on the board
  function automatic bit model_win(input logic [1:0] c);
    int dr [4];
    int dc [4];
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int r = 0; r < 10; r++)
      for (int q = 0; q < 10; q++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int s = 0; s < 5; s++) begin
            int rr = r + dr[d] * s;
            int cc = q + dc[d] * s;
            if (rr < 0 || rr > 9 || cc < 0 || cc > 9) ok = 1'b0;
            else if (mb[rr*10 + cc] != c) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic strobe(input bit p, input bit u, input int pos);
    @(negedge clk);
    io.cursor_pos = 8'(pos);
    io.put_req    = p;
    io.undo_req   = u;
    @(negedge clk);
    io.put_req    = 1'b0;
    io.undo_req   = 1'b0;
  endtask

  task automatic do_req(input bit p, input bit u, input int pos);
    exp_t e;
    logic [1:0] c;
    e.rej = 1'b0;
    if (u) begin
      if (mcount == 0) e.rej = 1'b1;
      else begin
        mb[hist.pop_back()] = 2'b00;
        mcount--;
        if (!mgo) mturn = ~mturn;
        mgo  = 1'b0;
        mwin = 2'b00;
      end
    end else if (p) begin
      if (mgo || pos >= 100) e.rej = 1'b1;
      else if (mb[pos] != 2'b00) e.rej = 1'b1;
      else begin
        c = mturn ? 2'b11 : 2'b10;
        mb[pos] = c;
        mcount++;
        hist.push_back(pos);
        if (model_win(c)) begin mgo = 1'b1; mwin = c; end
        else if (mcount == 100) begin mgo = 1'b1; mwin = 2'b01; end
        else mturn = ~mturn;
      end
    end
    e.board = pack_board();
    e.mc    = mcount;
    e.turn  = mturn;
    e.go    = mgo;
    e.win   = mwin;
    sb.push_back(e);
    strobe(p, u, pos);
    chk("reject_now", io.reject, e.rej);
    if (p && !u && !e.rej) chk("busy_start", io.busy, 1);
  endtask

  task automatic finish_req();
    exp_t e;
    int n;
    e = sb.pop_front();
    n = 0;
    while (io.busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_len_le32", (n <= 32), 1);
    if (e.rej) begin
      @(negedge clk);
      chk("reject_pulse_end", io.reject, 0);
    end
    chk("board", io.board_state, e.board);
    chk("move_count", io.move_count, e.mc);
    chk("turn", io.turn, e.turn);
    chk("game_over", io.game_over, e.go);
    chk("winner", io.winner, e.win);
    chk("busy_idle", io.busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_board"}, io.board_state, 0);
    chk({tag, "_mc"}, io.move_count, 0);
    chk({tag, "_turn"}, io.turn, 0);
    chk({tag, "_busy"}, io.busy, 0);
    chk({tag, "_go"}, io.game_over, 0);
    chk({tag, "_winner"}, io.winner, 0);
    chk({tag, "_reject"}, io.reject, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    io.cursor_pos = 8'd44;
    io.put_req    = 1'b1;
    io.undo_req   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("rst");

    // Request held through the first edge after release must be ignored
    rst = 1'b1;
    @(negedge clk);
    io.put_req = 1'b0;
    chk_all_zero("post_rst");

    // First placement, then occupied cell, then undo back to empty
    do_req(1, 0, 44); finish_req();
    chk("cell44_black", io.board_state[89:88], 2'b10);
    do_req(1, 0, 44); finish_req();
    do_req(0, 1, 0);  finish_req();
    do_req(0, 1, 0);  finish_req();

    // Black wins horizontally on row 4
    for (int i = 0; i < 4; i++) begin
      do_req(1, 0, 40 + i); finish_req();
      do_req(1, 0, 50 + i); finish_req();
    end
    do_req(1, 0, 44); finish_req();
    chk("win_flag", io.game_over, 1);
    do_req(1, 0, 77); finish_req();
    do_req(0, 1, 0);  finish_req();
    chk("undo_cell44", io.board_state[89:88], 2'b00);

    // Requests during the line check are refused, the check still completes
    do_req(1, 0, 44);
    strobe(0, 1, 0);
    chk("check_undo_reject", io.reject, 1);
    finish_req();
    do_req(0, 1, 0); finish_req();

    // Reset asserted while the line check is running
    strobe(1, 0, 45);
    chk("mid_busy", io.busy, 1);
    #1 rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Stones straddling a row boundary must not form a line
    do_req(1, 0, 8);  finish_req();
    do_req(1, 0, 90); finish_req();
    do_req(1, 0, 9);  finish_req();
    for (int i = 0; i < 3; i++) begin
      do_req(1, 0, 91 + i); finish_req();
      do_req(1, 0, 10 + i); finish_req();
    end
    chk("no_wrap_win", io.game_over, 0);

    // Out-of-range cursor, then simultaneous put and undo
    do_req(1, 0, 100); finish_req();
    do_req(1, 1, 0);   finish_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
